// File: rtl/modbus_vending_machine_top.sv
// -----------------------------------------------------------------------------
// modbus_vending_machine_top
//
// Modbus RTU slave controlling a 4-item vending machine. Receives requests on
// an 8N1 UART line, frames them by line silence, validates CRC-16/Modbus and
// slave address, then serves FC 03 (read stock registers) and FC 06 (write a
// stock register, or dispense an item through register 0x0100). Replies go out
// on an 8N1 UART transmitter with the CRC appended low byte first.
//
// Ports:
//   clk_sys        in   system clock, all logic on rising edge
//   rst            in   asynchronous active-low reset
//   uart_rx        in   serial request line, idle high
//   uart_tx        out  serial reply line, idle high
//   item_dispensed out  one-hot dispense strobe, DISP_CYCLES clocks long
//   item_select    out  one-hot item of the last accepted dispense, held
//   machine_status out  {stock[3..0]!=0, sold_out, exception, crc_err, busy}
// -----------------------------------------------------------------------------
module modbus_vending_machine_top #(
  parameter int          CLKS_PER_BIT = 2604,
  parameter logic [7:0]  SLAVE_ID     = 8'h01,
  parameter int          SILENCE_BITS = 39,
  parameter logic [15:0] INIT_STOCK   = 16'd10,
  parameter int          DISP_CYCLES  = 16
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [3:0] item_dispensed,
  output logic [3:0] item_select,
  output logic [7:0] machine_status
);

  localparam int SIL_CYC = SILENCE_BITS * CLKS_PER_BIT;
  localparam int CW      = $clog2(CLKS_PER_BIT);
  localparam int SW      = $clog2(SIL_CYC + 1);
  localparam int DW      = $clog2(DISP_CYCLES + 1);

  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {M_IDLE, M_EXEC, M_TX} main_state_t;

  // ---------------------------------------------------------------- RX path
  logic [1:0]    rx_sync_reg;
  logic          rx_prev_reg;
  logic          rx_s;
  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic          rx_valid_reg;
  logic          rx_tick;

  assign rx_s = rx_sync_reg[1];
  // The start state waits half a bit to land in mid-bit; later bits wait a full bit.
  assign rx_tick = (rx_state_reg == RX_START) ? (rx_cnt_reg == CW'(CLKS_PER_BIT/2 - 1))
                                              : (rx_cnt_reg == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rx_prev_reg && !rx_s) rx_state_next = RX_START;
      RX_START: if (rx_tick) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      rx_sync_reg  <= 2'b11;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], uart_rx};
      rx_prev_reg  <= rx_s;
      rx_state_reg <= rx_state_next;
      rx_valid_reg <= 1'b0;
      if (rx_state_reg == RX_IDLE || rx_tick) rx_cnt_reg <= '0;
      else                                    rx_cnt_reg <= rx_cnt_reg + 1'b1;
      if (rx_state_reg == RX_START) rx_bit_reg <= '0;
      if (rx_state_reg == RX_DATA && rx_tick) begin
        rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
        rx_bit_reg   <= rx_bit_reg + 1'b1;
      end
      // A low stop bit silently discards the byte.
      if (rx_state_reg == RX_STOP && rx_tick && rx_s) rx_valid_reg <= 1'b1;
    end
  end

  // ------------------------------------------------------- framing / buffer
  main_state_t   main_state_reg, main_state_next;
  logic [SW-1:0] sil_cnt_reg;
  logic [7:0]    frame_buf [0:7];
  logic [3:0]    byte_cnt_reg;   // saturates at 9 to mark an overlong frame
  logic [15:0]   rx_crc_reg;
  logic          frame_close;

  assign frame_close = (sil_cnt_reg == SW'(SIL_CYC)) && (byte_cnt_reg != 4'd0) &&
                       (main_state_reg == M_IDLE);

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      sil_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      rx_crc_reg   <= 16'hFFFF;
      for (int i = 0; i < 8; i++) frame_buf[i] <= '0;
    end else begin
      if (rx_state_reg != RX_IDLE || !rx_s) sil_cnt_reg <= '0;
      else if (sil_cnt_reg != SW'(SIL_CYC)) sil_cnt_reg <= sil_cnt_reg + 1'b1;

      if (main_state_reg == M_EXEC) begin
        byte_cnt_reg <= '0;
        rx_crc_reg   <= 16'hFFFF;
      end else if (rx_valid_reg && main_state_reg == M_IDLE) begin
        if (byte_cnt_reg < 4'd8) frame_buf[byte_cnt_reg[2:0]] <= rx_shift_reg;
        if (byte_cnt_reg != 4'd9) byte_cnt_reg <= byte_cnt_reg + 1'b1;
        rx_crc_reg <= crc16_step(rx_crc_reg, rx_shift_reg);
      end
    end
  end

  // ---------------------------------------------------------------- decode
  logic [15:0] stock_reg [0:3];
  logic [7:0]  fc;
  logic [15:0] reg_addr, reg_val;
  logic        frame_ok, id_ok, sold_out, do_write, do_disp;
  logic [7:0]  exc_code;

  assign fc       = frame_buf[1];
  assign reg_addr = {frame_buf[2], frame_buf[3]};
  assign reg_val  = {frame_buf[4], frame_buf[5]};
  // Running CRC over all 8 bytes including the appended CRC leaves a zero residue.
  assign frame_ok = (byte_cnt_reg == 4'd8) && (rx_crc_reg == 16'h0000);
  assign id_ok    = (frame_buf[0] == SLAVE_ID);

  always_comb begin
    exc_code = 8'h00;
    sold_out = 1'b0;
    do_write = 1'b0;
    do_disp  = 1'b0;
    case (fc)
      8'h03: begin
        if (reg_val == 16'd0 || reg_val > 16'd4)                exc_code = 8'h03;
        else if (({1'b0, reg_addr} + {1'b0, reg_val}) > 17'd4)  exc_code = 8'h02;
      end
      8'h06: begin
        if (reg_addr < 16'd4) do_write = 1'b1;
        else if (reg_addr == 16'h0100) begin
          if (reg_val > 16'd3) exc_code = 8'h03;
          else if (stock_reg[reg_val[1:0]] == 16'd0) begin
            exc_code = 8'h04;
            sold_out = 1'b1;
          end else do_disp = 1'b1;
        end else exc_code = 8'h02;
      end
      default: exc_code = 8'h01;
    endcase
  end

  // ------------------------------------------------------------ main FSM
  logic          tx_active_reg;
  logic [3:0]    tx_idx_reg, tx_len_reg;
  logic          tx_done;

  assign tx_done = (main_state_reg == M_TX) && !tx_active_reg && (tx_idx_reg == tx_len_reg + 4'd2);

  always_comb begin
    main_state_next = main_state_reg;
    case (main_state_reg)
      M_IDLE:  if (frame_close) main_state_next = M_EXEC;
      M_EXEC:  main_state_next = (frame_ok && id_ok) ? M_TX : M_IDLE;
      M_TX:    if (tx_done) main_state_next = M_IDLE;
      default: main_state_next = M_IDLE;
    endcase
  end

  // -------------------------------------------------- execute / registers
  logic [7:0]    resp_reg [0:10];
  logic [3:0]    item_select_reg;
  logic [DW-1:0] disp_cnt_reg;
  logic          st_crc_reg, st_exc_reg, st_sold_reg;

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      main_state_reg  <= M_IDLE;
      for (int i = 0; i < 4; i++)  stock_reg[i] <= INIT_STOCK;
      for (int i = 0; i < 11; i++) resp_reg[i]  <= '0;
      tx_len_reg      <= '0;
      item_select_reg <= '0;
      disp_cnt_reg    <= '0;
      st_crc_reg      <= 1'b0;
      st_exc_reg      <= 1'b0;
      st_sold_reg     <= 1'b0;
    end else begin
      main_state_reg <= main_state_next;
      if (disp_cnt_reg != '0) disp_cnt_reg <= disp_cnt_reg - 1'b1;
      if (main_state_reg == M_EXEC) begin
        st_crc_reg  <= !frame_ok;
        st_exc_reg  <= frame_ok && id_ok && (exc_code != 8'h00);
        st_sold_reg <= frame_ok && id_ok && sold_out;
        if (frame_ok && id_ok) begin
          resp_reg[0] <= SLAVE_ID;
          resp_reg[1] <= fc;
          if (exc_code != 8'h00) begin
            resp_reg[1] <= fc | 8'h80;
            resp_reg[2] <= exc_code;
            tx_len_reg  <= 4'd3;
          end else if (fc == 8'h03) begin
            resp_reg[2] <= {reg_val[6:0], 1'b0};
            // All four slots are filled; only the first qty are sent.
            for (int i = 0; i < 4; i++) begin
              resp_reg[3 + 2*i] <= stock_reg[reg_addr[1:0] + 2'(i)][15:8];
              resp_reg[4 + 2*i] <= stock_reg[reg_addr[1:0] + 2'(i)][7:0];
            end
            tx_len_reg <= 4'd3 + {reg_val[2:0], 1'b0};
          end else begin
            for (int i = 2; i < 6; i++) resp_reg[i] <= frame_buf[i];
            tx_len_reg <= 4'd6;
            if (do_write) stock_reg[reg_addr[1:0]] <= reg_val;
            if (do_disp) begin
              stock_reg[reg_val[1:0]] <= stock_reg[reg_val[1:0]] - 16'd1;
              item_select_reg         <= 4'b0001 << reg_val[1:0];
              disp_cnt_reg            <= DW'(DISP_CYCLES);
            end
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- TX path
  logic [9:0]    tx_shift_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [3:0]    tx_bit_reg;
  logic [15:0]   tx_crc_reg;
  logic          tx_load;
  logic [7:0]    tx_byte;

  assign tx_load = (main_state_reg == M_TX) && !tx_active_reg && (tx_idx_reg != tx_len_reg + 4'd2);
  // Payload bytes first, then the CRC accumulated over them, low byte first.
  assign tx_byte = (tx_idx_reg < tx_len_reg)  ? resp_reg[tx_idx_reg] :
                   (tx_idx_reg == tx_len_reg) ? tx_crc_reg[7:0] : tx_crc_reg[15:8];

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      tx_active_reg <= 1'b0;
      tx_shift_reg  <= '1;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_idx_reg    <= '0;
      tx_crc_reg    <= 16'hFFFF;
    end else if (main_state_reg == M_EXEC) begin
      tx_idx_reg <= '0;
      tx_crc_reg <= 16'hFFFF;
    end else if (tx_load) begin
      tx_shift_reg  <= {1'b1, tx_byte, 1'b0};
      tx_active_reg <= 1'b1;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_idx_reg    <= tx_idx_reg + 1'b1;
      if (tx_idx_reg < tx_len_reg) tx_crc_reg <= crc16_step(tx_crc_reg, tx_byte);
    end else if (tx_active_reg) begin
      if (tx_cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
        tx_cnt_reg   <= '0;
        tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
        if (tx_bit_reg == 4'd9) tx_active_reg <= 1'b0;
        else                    tx_bit_reg    <= tx_bit_reg + 1'b1;
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign uart_tx        = tx_active_reg ? tx_shift_reg[0] : 1'b1;
  assign item_select    = item_select_reg;
  assign item_dispensed = (disp_cnt_reg != '0) ? item_select_reg : 4'b0000;
  assign machine_status = {stock_reg[3] != 16'd0, stock_reg[2] != 16'd0,
                           stock_reg[1] != 16'd0, stock_reg[0] != 16'd0,
                           st_sold_reg, st_exc_reg, st_crc_reg,
                           main_state_reg != M_IDLE};

endmodule

// File: tb/tb_modbus_vending_machine_top.sv
// -----------------------------------------------------------------------------
// tb_modbus_vending_machine_top
//
// Drives Modbus RTU requests onto uart_rx, decodes uart_tx with a bit-level
// UART monitor and compares every reply byte against a queue of expected bytes
// pushed when the request is issued. Status, item_select and dispense pulse
// width are checked after each transaction.
// -----------------------------------------------------------------------------
module tb_modbus_vending_machine_top;

  localparam int CPB     = 16;
  localparam int SIL_CYC = 39 * CPB;

  logic       clk_sys = 1'b0;
  logic       rst     = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [3:0] item_dispensed;
  logic [3:0] item_select;
  logic [7:0] machine_status;

  always #5 clk_sys = ~clk_sys;

  modbus_vending_machine_top #(
    .CLKS_PER_BIT(CPB),
    .SLAVE_ID    (8'h01),
    .SILENCE_BITS(39),
    .INIT_STOCK  (16'd10),
    .DISP_CYCLES (16)
  ) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .item_dispensed(item_dispensed),
    .item_select   (item_select),
    .machine_status(machine_status)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC-16/Modbus, fed one data bit at a time.
  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  // ------------------------------------------------------ UART monitor
  logic [7:0] rx_mem [0:255];
  int         rx_wr = 0;

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (CPB/2) @(negedge clk_sys);
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_sys);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk_sys);
        rx_mem[rx_wr % 256] = b;
        rx_wr++;
      end
    end
  end

  // Dispense pulse accounting.
  int         disp_total = 0;
  logic [3:0] disp_last  = 4'b0;
  always @(negedge clk_sys) begin
    if (item_dispensed != 4'b0) begin
      disp_total <= disp_total + 1;
      disp_last  <= item_dispensed;
    end
  end

  // ------------------------------------------------------ stimulus helpers
  logic [7:0] req [0:15];
  int         req_len;
  logic [7:0] rsp [0:15];
  int         rsp_len;
  logic [7:0] exp_q [$];
  int         rx_rd = 0;
  int         extra_cnt = 0;

  task automatic set_req(input logic [7:0] id, input logic [7:0] fc,
                         input logic [15:0] a, input logic [15:0] v, input bit bad_crc);
    logic [15:0] c;
    req[0] = id;      req[1] = fc;
    req[2] = a[15:8]; req[3] = a[7:0];
    req[4] = v[15:8]; req[5] = v[7:0];
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++) c = ref_crc(c, req[i]);
    req[6] = c[7:0] ^ (bad_crc ? 8'h5A : 8'h00);
    req[7] = c[15:8];
    req_len = 8;
  endtask

  task automatic push_rsp();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < rsp_len; i++) begin
      c = ref_crc(c, rsp[i]);
      exp_q.push_back(rsp[i]);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic exp_echo();
    for (int i = 0; i < 6; i++) rsp[i] = req[i];
    rsp_len = 6;
    push_rsp();
  endtask

  task automatic exp_exc(input logic [7:0] fc, input logic [7:0] code);
    rsp[0] = 8'h01; rsp[1] = fc | 8'h80; rsp[2] = code;
    rsp_len = 3;
    push_rsp();
  endtask

  task automatic exp_read(input int qty, input logic [15:0] v0, input logic [15:0] v1,
                          input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] v [0:3];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    rsp[0] = 8'h01; rsp[1] = 8'h03; rsp[2] = 8'(2 * qty);
    for (int i = 0; i < qty; i++) begin
      rsp[3 + 2*i] = v[i][15:8];
      rsp[4 + 2*i] = v[i][7:0];
    end
    rsp_len = 3 + 2 * qty;
    push_rsp();
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk_sys);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk_sys);
    end
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk_sys);
  endtask

  task automatic send_frame();
    for (int i = 0; i < req_len; i++) send_byte(req[i]);
  endtask

  task automatic drain(input string name);
    logic [7:0] b;
    logic [7:0] e;
    while (rx_rd != rx_wr) begin
      b = rx_mem[rx_rd % 256];
      rx_rd++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val({name, "_byte"}, {24'h0, b}, {24'h0, e});
      end else begin
        extra_cnt++;
      end
    end
  endtask

  task automatic run_txn(input string name);
    int to;
    extra_cnt = 0;
    send_frame();
    to = 0;
    while (to < 8000) begin
      @(negedge clk_sys);
      to++;
      drain(name);
      if (to > SIL_CYC + 100 && exp_q.size() == 0 && !machine_status[0]) break;
    end
    repeat (3 * CPB) begin
      @(negedge clk_sys);
      drain(name);
    end
    check_val({name, "_missing"}, exp_q.size(), 0);
    check_val({name, "_extra"}, extra_cnt, 0);
    exp_q.delete();
    $display("[TB] txn %s: %0d request bytes, tests so far %0d, failed %0d",
             name, req_len, n_tests, n_fail);
  endtask

  // ------------------------------------------------------ test sequence
  initial begin : main_seq
    int d0;
    int to;
    bit started;

    repeat (5) @(negedge clk_sys);
    check_val("rst_uart_tx", uart_tx, 1);
    check_val("rst_dispensed", item_dispensed, 0);
    check_val("rst_select", item_select, 0);
    check_val("rst_status", machine_status, 8'hF0);
    rst = 1'b1;
    repeat (50) @(negedge clk_sys);

    // Literal request with the CRC bytes as published: 01 03 0001 0001 D5 CA.
    req[0] = 8'h01; req[1] = 8'h03; req[2] = 8'h00; req[3] = 8'h01;
    req[4] = 8'h00; req[5] = 8'h01; req[6] = 8'hD5; req[7] = 8'hCA;
    req_len = 8;
    exp_read(1, 16'h000A, 16'h0, 16'h0, 16'h0);
    run_txn("rd_stock1");
    check_val("rd_stock1_status", machine_status, 8'hF0);

    set_req(8'h01, 8'h06, 16'h0000, 16'h1234, 0);
    exp_echo();
    run_txn("wr_stock0");
    check_val("wr_stock0_status", machine_status, 8'hF0);

    d0 = disp_total;
    set_req(8'h01, 8'h06, 16'h0100, 16'h0001, 0);
    exp_echo();
    run_txn("disp1");
    check_val("disp1_select", item_select, 4'b0010);
    check_val("disp1_pulse_len", disp_total - d0, 16);
    check_val("disp1_pulse_item", disp_last, 4'b0010);
    check_val("disp1_pulse_off", item_dispensed, 0);

    set_req(8'h01, 8'h03, 16'h0000, 16'h0004, 0);
    exp_read(4, 16'h1234, 16'h0009, 16'h000A, 16'h000A);
    run_txn("rd_all");

    set_req(8'h01, 8'h99, 16'h0001, 16'h0001, 0);
    exp_exc(8'h99, 8'h01);
    run_txn("bad_fc");
    check_val("bad_fc_status", machine_status, 8'hF4);

    set_req(8'h01, 8'h06, 16'h0002, 16'h0000, 0);
    exp_echo();
    run_txn("wr_stock2_zero");
    check_val("wr_stock2_status", machine_status, 8'hB0);

    d0 = disp_total;
    set_req(8'h01, 8'h06, 16'h0100, 16'h0002, 0);
    exp_exc(8'h06, 8'h04);
    run_txn("disp_soldout");
    check_val("soldout_status", machine_status, 8'hBC);
    check_val("soldout_select", item_select, 4'b0010);
    check_val("soldout_no_pulse", disp_total - d0, 0);

    set_req(8'h01, 8'h03, 16'h0000, 16'h0001, 1);
    run_txn("bad_crc");
    check_val("bad_crc_status", machine_status, 8'hB2);

    set_req(8'h02, 8'h03, 16'h0000, 16'h0001, 0);
    run_txn("other_slave");
    check_val("other_slave_status", machine_status, 8'hB0);

    set_req(8'h01, 8'h03, 16'h0003, 16'h0002, 0);
    exp_exc(8'h03, 8'h02);
    run_txn("rd_range");
    check_val("rd_range_status", machine_status, 8'hB4);

    set_req(8'h01, 8'h03, 16'h0000, 16'h0005, 0);
    exp_exc(8'h03, 8'h03);
    run_txn("rd_qty5");

    set_req(8'h01, 8'h03, 16'h0000, 16'h0000, 0);
    exp_exc(8'h03, 8'h03);
    run_txn("rd_qty0");

    set_req(8'h01, 8'h06, 16'h0100, 16'h0005, 0);
    exp_exc(8'h06, 8'h03);
    run_txn("disp_badval");

    set_req(8'h01, 8'h06, 16'h0200, 16'h0001, 0);
    exp_exc(8'h06, 8'h02);
    run_txn("wr_badreg");

    set_req(8'h01, 8'h06, 16'h0003, 16'hFFFF, 0);
    exp_echo();
    run_txn("wr_stock3_ffff");

    set_req(8'h01, 8'h03, 16'h0002, 16'h0002, 0);
    exp_read(2, 16'h0000, 16'hFFFF, 16'h0, 16'h0);
    run_txn("rd_top2");
    check_val("rd_top2_status", machine_status, 8'hB0);

    set_req(8'h01, 8'h03, 16'h0000, 16'h0001, 0);
    req_len = 6;
    run_txn("short_frame");
    check_val("short_status", machine_status, 8'hB2);

    set_req(8'h01, 8'h03, 16'h0000, 16'h0001, 0);
    req[8] = 8'h00;
    req_len = 9;
    run_txn("long_frame");
    check_val("long_status", machine_status, 8'hB2);

    // Reset while a reply is on the line.
    set_req(8'h01, 8'h03, 16'h0000, 16'h0004, 0);
    send_frame();
    started = 0;
    to = 0;
    while (!started && to < SIL_CYC + 500) begin
      @(negedge clk_sys);
      to++;
      if (uart_tx == 1'b0) started = 1;
    end
    check_val("rst_mid_reply_started", started, 1);
    repeat (3 * CPB) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    check_val("rst_mid_uart_tx", uart_tx, 1);
    check_val("rst_mid_status", machine_status, 8'hF0);
    check_val("rst_mid_select", item_select, 0);
    repeat (5) @(negedge clk_sys);
    rst = 1'b1;
    repeat (20 * CPB) @(negedge clk_sys);
    rx_rd = rx_wr;
    exp_q.delete();

    set_req(8'h01, 8'h03, 16'h0000, 16'h0004, 0);
    exp_read(4, 16'h000A, 16'h000A, 16'h000A, 16'h000A);
    run_txn("rd_after_rst");
    check_val("after_rst_status", machine_status, 8'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/modbus_vending_machine_top.md
Name: modbus_vending_machine_top

Overview:
Modbus RTU slave that controls a 4-item vending machine. The block sits between a half-duplex UART line (19200 baud, 8N1) and the vending mechanism. It holds the per-item stock registers, and serves FC 03 (read holding registers) and FC 06 (write single register, including the dispense command). Single clock domain: baud timing is derived from clk_sys.

Parameters:
CLKS_PER_BIT, 2604, clk_sys cycles per UART bit (50 MHz / 19200)
SLAVE_ID, 8'h01, Modbus address answered
SILENCE_BITS, 39, idle bit-times on uart_rx that end a frame (3.5 chars x 11 bits, rounded up)
INIT_STOCK, 16'd10, reset value of each stock register
DISP_CYCLES, 16, clk_sys cycles item_dispensed stays asserted

Ports:
clk_sys input 1 system clock, all logic on rising edge
rst input 1 asynchronous active-low reset
uart_rx input 1 serial in, idle high, 8N1, LSB first
uart_tx output 1 serial out, idle high, 8N1, LSB first
item_dispensed output 4 one-hot dispense strobe, item n -> bit n
item_select output 4 one-hot item of the last accepted dispense, held
machine_status output 8 status flags, see Behaviour

Behaviour:
- Reset (rst=0): uart_tx=1, item_dispensed=0, item_select=0, machine_status=8'hF0, stock[0..3]=INIT_STOCK, RX buffer and TX cleared.
- UART RX:
  - Start bit = falling edge; re-sampled at CLKS_PER_BIT/2; if high there, ignored.
  - Data bits sampled at mid-bit. A stop bit of 0 discards the byte.
- Framing:
  - Bytes are appended to an 8-byte buffer.
  - SILENCE_BITS*CLKS_PER_BIT idle-high cycles after the last stop bit close the frame.
  - Frames longer than 8 bytes are flagged overlong.
  - Bytes arriving while a response is being transmitted are discarded.
- Validation:
  - CRC-16/Modbus (poly 0xA001 reflected, init 0xFFFF) is updated per received byte. The frame is good when length==8, the CRC over all 8 bytes is 0 (CRC low byte sent first), and byte0==SLAVE_ID.
  - Any other frame is dropped silently: no reply, machine_status[1]=1 on CRC/length fail.
- FC 03:
  - addr 0x0000-0x0003 = stock[0..3].
  - qty in 1..4 and addr+qty<=4: reply ID,03,2*qty, then data hi/lo per register, then CRC.
  - qty=0 or qty>4: exception 03. Out of range: exception 02.
- FC 06, reg 0x0000-0x0003: set stock[reg]=value; echo the request.
- FC 06, reg 0x0100 (dispense), value 0..3:
  - If stock>0: decrement stock, item_select=one-hot(value), item_dispensed=one-hot(value) for DISP_CYCLES cycles, echo the request.
  - If stock==0: exception 04 and machine_status[3]=1.
  - value>3: exception 03. Other register: exception 02.
- Any other FC: exception 01.
- Exception frame: ID, FC|0x80, code, CRC lo, CRC hi (5 bytes).
- TX:
  - Reply starts within 2 bit-times of frame close. Bytes are back-to-back with CRC appended low byte first.
  - machine_status[0]=1 from frame close until the last stop bit is sent.
- machine_status:
  - [0] busy; [1] last frame CRC/length error; [2] last reply was an exception; [3] last dispense sold-out.
  - [7:4] = (stock[n]!=0) per item.
  - Flags [1]-[3] are updated on every closed frame.
- Arithmetic: stock is 16-bit, decrement only when nonzero (no wrap). FC 06 value is written verbatim.
- A reset mid-frame or mid-reply aborts it immediately; uart_tx returns high.

Test Plan:
- After reset, FC 03 request 01 03 0001 0001 (CRC D5CA) -> reply 01 03 02 00 0A + CRC; machine_status=F0 when idle.
- 01 06 0100 0001 + CRC -> echo of the request; item_select=0010; item_dispensed=0010 for 16 cycles; stock[1]=9.
- 01 99 0001 0001 + CRC -> exception 01 99 01 + CRC; machine_status[2]=1.
- Set stock[2]=0 via 01 06 0002 0000, then dispense value 2 -> exception 86 04; machine_status[3]=1 and [6]=0.
- Good frame with a corrupted CRC byte, and a frame to slave 02 -> uart_tx stays high; CRC case sets machine_status[1].
- FC 03 with addr 0003, qty 2 -> exception 83 02. Assert rst during a reply -> uart_tx=1 and stock back to 10.
